// File: rtl/fade_pwm_if.sv
// fade_pwm_if: output bundle of fade_pwm (duty, fade direction, PWM waveform).
// Revision: 1.0 - initial release
`default_nettype none

interface fade_pwm_if #(
    parameter int PWM_INTERVAL = 1200
);
    localparam int W = $clog2(PWM_INTERVAL + 1);

    logic [W-1:0] pwm_value;
    logic         fade_up;
    logic         pwm_out;

    modport master (output pwm_value, output fade_up, output pwm_out);
    modport slave  (input  pwm_value, input  fade_up, input  pwm_out);
endinterface

`default_nettype wire

// File: rtl/fade_pwm.sv
// fade_pwm: triangle-fading PWM generator; duty ramps 0..PWM_INTERVAL and back.
// Macro FADE_PWM_ACTIVE_LOW_EN inverts pwm_out. Revision: 1.0 - initial release
`default_nettype none

module fade_pwm #(
    parameter int PWM_INTERVAL     = 1200,
    parameter int INC_DEC_INTERVAL = 10000,
    parameter int INC_DEC_MAX      = 200
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fade_pwm_if.master  bus
);
    localparam int W    = $clog2(PWM_INTERVAL + 1);
    localparam int SW   = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
    localparam int STEP = (INC_DEC_MAX >= 1) ? (PWM_INTERVAL / INC_DEC_MAX) : 1;

    localparam logic [W-1:0]  FULL      = W'(PWM_INTERVAL);
    localparam logic [W-1:0]  STEP_W    = W'(STEP);
    localparam logic [W-1:0]  PWM_LAST  = W'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_INTERVAL - 1);

    generate
        if (PWM_INTERVAL < 1 || INC_DEC_INTERVAL < 1 || INC_DEC_MAX < 1 ||
            (PWM_INTERVAL % INC_DEC_MAX) != 0) begin : g_bad_params
            $error("fade_pwm: illegal parameter set");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_t;

    state_t         state_q,    state_d;
    logic [W-1:0]   pwm_cnt_q,  pwm_cnt_d;
    logic [SW-1:0]  step_cnt_q, step_cnt_d;
    logic [W-1:0]   value_q,    value_d;
    logic           step_tick;
    logic           pwm_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UP;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            value_q    <= '0;
        end else begin
            state_q    <= state_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            value_q    <= value_d;
        end
    end

    assign step_tick = (step_cnt_q == STEP_LAST);

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;

        // Compare against the end point before adding/subtracting so the
        // arithmetic can never wrap, even for the last step of a ramp.
        if (step_tick) begin
            case (state_q)
                ST_UP: begin
                    if (value_q >= FULL - STEP_W) begin
                        value_d = FULL;
                        state_d = ST_DOWN;
                    end else begin
                        value_d = value_q + STEP_W;
                    end
                end
                default: begin
                    if (value_q <= STEP_W) begin
                        value_d = '0;
                        state_d = ST_UP;
                    end else begin
                        value_d = value_q - STEP_W;
                    end
                end
            endcase
        end
    end

    assign pwm_on        = (pwm_cnt_q < value_q);
    assign bus.pwm_value = value_q;
    assign bus.fade_up   = (state_q == ST_UP);

`ifdef FADE_PWM_ACTIVE_LOW_EN
    assign bus.pwm_out = ~pwm_on;
`else
    assign bus.pwm_out = pwm_on;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fade_pwm.sv
// tb_fade_pwm: directed self-checking bench for fade_pwm (12/4/4, STEP=3).
// Revision: 1.0 - initial release
`default_nettype none

module tb_fade_pwm;
    localparam int PWM_INTERVAL     = 12;
    localparam int INC_DEC_INTERVAL = 4;
    localparam int INC_DEC_MAX      = 4;

`ifdef FADE_PWM_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Duty after each 4-cycle step group within one 32-cycle triangle period.
    int exp_val [0:7] = '{0, 3, 6, 9, 12, 9, 6, 3};
    int exp_up  [0:7] = '{1, 1, 1, 1, 0, 0, 0, 0};

    fade_pwm_if #(.PWM_INTERVAL(PWM_INTERVAL)) u_if ();

    fade_pwm #(
        .PWM_INTERVAL     (PWM_INTERVAL),
        .INC_DEC_INTERVAL (INC_DEC_INTERVAL),
        .INC_DEC_MAX      (INC_DEC_MAX)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // k counts posedges since reset release; samples are taken on negedges.
    task automatic run_and_check(input int n);
        int  e;
        logic exp_out;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e       = (k / 4) % 8;
            exp_out = ((k % PWM_INTERVAL) < exp_val[e]) ^ ACT_LOW;
            check_eq($sformatf("value@%0d", k), 32'(u_if.pwm_value), 32'(exp_val[e]));
            check_eq($sformatf("fade_up@%0d", k), 32'(u_if.fade_up), 32'(exp_up[e]));
            check_eq($sformatf("pwm_out@%0d", k), 32'(u_if.pwm_out), 32'(exp_out));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_value", 32'(u_if.pwm_value), 32'd0);
        check_eq("rst_fade_up", 32'(u_if.fade_up), 32'd1);
        check_eq("rst_pwm_out", 32'(u_if.pwm_out), 32'(ACT_LOW));
        rst = 1'b0;

        // Two full periods plus the fall up to value 9 on a step-tick cycle.
        run_and_check(64 + 23);
        check_eq("pre_rst_value", 32'(u_if.pwm_value), 32'd9);
        check_eq("pre_rst_fade_up", 32'(u_if.fade_up), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_value", 32'(u_if.pwm_value), 32'd0);
        check_eq("midrst_fade_up", 32'(u_if.fade_up), 32'd1);
        check_eq("midrst_pwm_out", 32'(u_if.pwm_out), 32'(ACT_LOW));
        rst = 1'b0;

        // Both counters must have restarted from 0 for this to line up.
        run_and_check(16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
